// File: rtl/memory_access_pkg.sv
// Shared encodings and helpers for the memory access controller.
package memory_access_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE_SETUP,
        ST_WRITE_COMMIT,
        ST_RESPOND
    } state_t;

    // Illegal size is reported separately; this only covers natural alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return (addr_lo != 2'b00);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_aligner.sv
// Combinational lane logic: load extraction with sign/zero extension and
// store merge of a sub-word into the read-back memory word.
module load_store_aligner
    import memory_access_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (lane_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        load_data_o = rdata_i;
        case (size_i)
            SIZE_BYTE: load_data_o = unsigned_i ? {24'h0, byte_sel}
                                                : {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_data_o = unsigned_i ? {16'h0, half_sel}
                                                : {{16{half_sel[15]}}, half_sel};
            default:   load_data_o = rdata_i;
        endcase
    end

    always_comb begin
        merged_o = rdata_i;
        case (size_i)
            SIZE_BYTE: begin
                case (lane_i)
                    2'd0: merged_o[7:0]   = wdata_i[7:0];
                    2'd1: merged_o[15:8]  = wdata_i[7:0];
                    2'd2: merged_o[23:16] = wdata_i[7:0];
                    2'd3: merged_o[31:24] = wdata_i[7:0];
                    default: merged_o = rdata_i;
                endcase
            end
            SIZE_HALF: begin
                if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
                else           merged_o[15:0]  = wdata_i[15:0];
            end
            SIZE_WORD: merged_o = wdata_i;
            default:   merged_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_access_controller.sv
// Core-side initiator: turns load/store requests into the memory's
// read-rising / write-falling strobe protocol with registered memory outputs.
module memory_access_controller
    import memory_access_pkg::*;
#(
    parameter int MEM_DEPTH     = 256,
    parameter int SETTLE_CYCLES = 1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    input  logic [31:0] mem_read_data
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic        unsigned_q, unsigned_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_re_q, mem_re_d;

    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    load_store_aligner u_aligner (
        .size_i      (size_q),
        .lane_i      (lane_q),
        .unsigned_i  (unsigned_q),
        .rdata_i     (mem_read_data),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged_word)
    );

    assign req_err = (req_size == SIZE_ILLEGAL)
                   || is_misaligned(req_size, req_address[1:0])
                   || ({2'b00, req_address[31:2]} >= 32'(MEM_DEPTH));

    // Ready is forced low while reset is held so every output reads 0 in reset.
    assign req_ready        = reset && (state_q == ST_IDLE);
    assign rsp_valid        = rsp_valid_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign rsp_error        = rsp_error_q;
    assign mem_address      = mem_address_q;
    assign mem_write_data   = mem_wdata_q;
    assign mem_write_enable = mem_we_q;
    assign mem_read_enable  = mem_re_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            size_q        <= '0;
            lane_q        <= '0;
            unsigned_q    <= 1'b0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            size_q        <= size_d;
            lane_q        <= lane_d;
            unsigned_q    <= unsigned_d;
            write_q       <= write_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_q      <= mem_we_d;
            mem_re_q      <= mem_re_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        size_d        = size_q;
        lane_d        = lane_q;
        unsigned_d    = unsigned_q;
        write_d       = write_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_we_d      = mem_we_q;
        mem_re_d      = mem_re_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    size_d     = req_size;
                    lane_d     = req_address[1:0];
                    unsigned_d = req_unsigned;
                    write_d    = req_write;
                    wdata_d    = req_wdata;
                    if (req_err) begin
                        state_d     = ST_RESPOND;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        mem_address_d = {2'b00, req_address[31:2]};
                        if (req_write && (req_size == SIZE_WORD)) begin
                            state_d     = ST_WRITE_SETUP;
                            mem_wdata_d = req_wdata;
                            mem_we_d    = 1'b1;
                        end else begin
                            state_d  = ST_READ;
                            mem_re_d = 1'b1;
                            cnt_d    = '0;
                        end
                    end
                end
            end
            ST_READ: begin
                if (cnt_q == SETTLE_LAST) begin
                    mem_re_d = 1'b0;
                    if (write_q) begin
                        state_d     = ST_WRITE_SETUP;
                        mem_wdata_d = merged_word;
                        mem_we_d    = 1'b1;
                    end else begin
                        state_d     = ST_RESPOND;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b0;
                        rsp_rdata_d = load_data;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_WRITE_SETUP: begin
                // Dropping the strobe here is the commit; address/data stay put.
                state_d  = ST_WRITE_COMMIT;
                mem_we_d = 1'b0;
            end
            ST_WRITE_COMMIT: begin
                state_d     = ST_RESPOND;
                rsp_valid_d = 1'b1;
                rsp_error_d = 1'b0;
                rsp_rdata_d = '0;
            end
            ST_RESPOND: begin
                state_d     = ST_IDLE;
                rsp_rdata_d = '0;
                rsp_error_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed bench for memory_access_controller with a behavioural strobe memory.
module tb_memory_access_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [31:0] mem_read_data = '0;

    always #5 clk = ~clk;

    memory_access_controller #(.MEM_DEPTH(256), .SETTLE_CYCLES(1)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_address      (req_address),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_error        (rsp_error),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_read_data    (mem_read_data)
    );

    // Behavioural memory: read on rising read strobe, write on falling write strobe.
    logic [31:0] mem [0:255];

    always @(posedge mem_read_enable) begin
        #1;
        mem_read_data = (mem_address < 32'd256) ? mem[mem_address[7:0]] : 32'h0;
    end

    always @(negedge mem_write_enable) begin
        if (reset === 1'b1 && mem_address < 32'd256)
            mem[mem_address[7:0]] = mem_write_data;
    end

    int          re_c = 0;
    int          we_c = 0;
    int          overlap = 0;
    logic [31:0] strobe_addr = '0;

    always @(negedge clk) begin
        if (mem_read_enable === 1'b1) re_c++;
        if (mem_write_enable === 1'b1) we_c++;
        if (mem_read_enable === 1'b1 && mem_write_enable === 1'b1) overlap++;
        if (mem_read_enable === 1'b1 || mem_write_enable === 1'b1) strobe_addr = mem_address;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {27'h0, req_ready, rsp_valid, rsp_error,
                              mem_write_enable, mem_read_enable}, 32'h0);
        check({tag, "_addr"},  mem_address,    32'h0);
        check({tag, "_rdata"}, rsp_rdata,      32'h0);
        check({tag, "_wdata"}, mem_write_data, 32'h0);
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er);
        @(negedge clk);
        re_c = 0;
        we_c = 0;
        strobe_addr = '0;
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_address  = addr;
        req_wdata    = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat = k;
                rd  = rsp_rdata;
                er  = rsp_error;
                break;
            end
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          re_cyc;
        int          we_cyc;
        logic [31:0] idx;
    } vec_t;

    function automatic vec_t mk(logic wr, logic [1:0] size, logic uns, logic [31:0] addr,
                                logic [31:0] wdata, int lat, logic [31:0] rdata, logic err,
                                int re_cyc, int we_cyc, logic [31:0] idx);
        vec_t v;
        v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.lat = lat; v.rdata = rdata; v.err = err;
        v.re_cyc = re_cyc; v.we_cyc = we_cyc; v.idx = idx;
        return v;
    endfunction

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        logic [5:0]  re_v, rdy_v, rsp_v;
        logic [31:0] rd_a, rd_b;

        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_address = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[3]   = 32'h11223344;
        mem[5]   = 32'h80013344;
        mem[255] = 32'h0BADF00D;

        //           wr    size   uns   addr          wdata         lat rdata         err  re we idx
        vecs[0]  = mk(1'b1, 2'b10, 1'b0, 32'h00000010, 32'hDEADBEEF, 3, 32'h00000000, 1'b0, 0, 1, 4);
        vecs[1]  = mk(1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0,        2, 32'hDEADBEEF, 1'b0, 1, 0, 4);
        vecs[2]  = mk(1'b1, 2'b00, 1'b0, 32'h0000000F, 32'h000000A5, 4, 32'h00000000, 1'b0, 1, 1, 3);
        vecs[3]  = mk(1'b0, 2'b00, 1'b0, 32'h0000000F, 32'h0,        2, 32'hFFFFFFA5, 1'b0, 1, 0, 3);
        vecs[4]  = mk(1'b0, 2'b00, 1'b1, 32'h0000000F, 32'h0,        2, 32'h000000A5, 1'b0, 1, 0, 3);
        vecs[5]  = mk(1'b0, 2'b01, 1'b0, 32'h00000016, 32'h0,        2, 32'hFFFF8001, 1'b0, 1, 0, 5);
        vecs[6]  = mk(1'b0, 2'b01, 1'b1, 32'h00000014, 32'h0,        2, 32'h00003344, 1'b0, 1, 0, 5);
        vecs[7]  = mk(1'b1, 2'b01, 1'b0, 32'h00000016, 32'h1234BEEF, 4, 32'h00000000, 1'b0, 1, 1, 5);
        vecs[8]  = mk(1'b0, 2'b01, 1'b1, 32'h00000016, 32'h0,        2, 32'h0000BEEF, 1'b0, 1, 0, 5);
        vecs[9]  = mk(1'b0, 2'b00, 1'b0, 32'h00000015, 32'h0,        2, 32'h00000033, 1'b0, 1, 0, 5);
        vecs[10] = mk(1'b0, 2'b00, 1'b0, 32'h00000017, 32'h0,        2, 32'hFFFFFFBE, 1'b0, 1, 0, 5);
        vecs[11] = mk(1'b0, 2'b10, 1'b1, 32'h00000014, 32'h0,        2, 32'hBEEF3344, 1'b0, 1, 0, 5);
        vecs[12] = mk(1'b0, 2'b01, 1'b0, 32'h00000011, 32'h0,        1, 32'h00000000, 1'b1, 0, 0, 0);
        vecs[13] = mk(1'b0, 2'b10, 1'b0, 32'h00000012, 32'h0,        1, 32'h00000000, 1'b1, 0, 0, 0);
        vecs[14] = mk(1'b0, 2'b11, 1'b0, 32'h00000020, 32'h0,        1, 32'h00000000, 1'b1, 0, 0, 0);
        vecs[15] = mk(1'b0, 2'b10, 1'b0, 32'h00000400, 32'h0,        1, 32'h00000000, 1'b1, 0, 0, 0);
        vecs[16] = mk(1'b1, 2'b00, 1'b0, 32'h00000401, 32'h000000FF, 1, 32'h00000000, 1'b1, 0, 0, 0);
        vecs[17] = mk(1'b0, 2'b10, 1'b0, 32'h000003FC, 32'h0,        2, 32'h0BADF00D, 1'b0, 1, 0, 255);
        vecs[18] = mk(1'b1, 2'b00, 1'b0, 32'h00000012, 32'h00000077, 4, 32'h00000000, 1'b0, 1, 1, 4);

        // Reset held for three cycles, then released.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_zero("in_reset");
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ready_after_release", {31'h0, req_ready}, 32'h1);
        check("rsp_after_release",   {31'h0, rsp_valid}, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            do_req(vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, lat, rd, er);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("v%0d_error", i), {31'h0, er}, {31'h0, vecs[i].err});
            check($sformatf("v%0d_re_cycles", i), re_c, vecs[i].re_cyc);
            check($sformatf("v%0d_we_cycles", i), we_c, vecs[i].we_cyc);
            if (!vecs[i].err)
                check($sformatf("v%0d_mem_address", i), strobe_addr, vecs[i].idx);
        end

        check("mem3_after_byte_store", mem[3], 32'hA5223344);
        check("mem5_after_half_store", mem[5], 32'hBEEF3344);
        check("mem4_after_byte_store", mem[4], 32'hDE77BEEF);
        check("strobe_overlap", overlap, 0);

        // Two loads back to back with req_valid held high throughout.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_address = 32'h00000010;
        re_v = '0; rdy_v = '0; rsp_v = '0; rd_a = '0; rd_b = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            re_v[i]  = mem_read_enable;
            rdy_v[i] = req_ready;
            rsp_v[i] = rsp_valid;
            if (i == 1) rd_a = rsp_rdata;
            if (i == 4) rd_b = rsp_rdata;
            if (i == 3) req_valid = 1'b0;
        end
        check("held_re_pattern",    {26'h0, re_v},  {26'h0, 6'b001001});
        check("held_ready_pattern", {26'h0, rdy_v}, {26'h0, 6'b100100});
        check("held_rsp_pattern",   {26'h0, rsp_v}, {26'h0, 6'b010010});
        check("held_rdata_first",  rd_a, 32'hDE77BEEF);
        check("held_rdata_second", rd_b, 32'hDE77BEEF);

        // Third load interrupted by reset while in READ.
        req_valid = 1'b1;
        req_address = 32'h00000014;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("third_load_in_read", {31'h0, mem_read_enable}, 32'h1);
        reset = 1'b0;
        #1;
        check_zero("mid_read_reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ready_after_mid_reset", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        check("idle_after_mid_reset", {30'h0, req_ready, rsp_valid}, 32'h2);

        do_req(1'b0, 2'b10, 1'b0, 32'h00000014, 32'h0, lat, rd, er);
        check("post_reset_latency", lat, 2);
        check("post_reset_rdata", rd, 32'hBEEF3344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/memory_access_controller.md
Name: memory_access_controller

Overview:
- Core-side initiator for the word-addressed cache memory interface. It turns pipeline load/store requests into the memory's strobe protocol:
  - reads are captured on the rising edge of read_enable;
  - writes commit on the falling edge of write_enable.
- Sits between the execute/memory stage and the memory interface.
- Handles byte/half/word sizes, sign extension, sub-word read-modify-write, and misalignment/range errors.

Parameters:
- MEM_DEPTH, 256, number of 32-bit words in the target memory; word indices at or above this are errors.
- SETTLE_CYCLES, 1, cycles read_enable is held high before mem_read_data is sampled (range 1 to 15).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request offered.
- req_ready  output  1  high only in IDLE; a request is accepted on the edge where req_valid && req_ready.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  zero-extend loads when 1.
- req_address  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  32  load result; 0 for stores and errors.
- rsp_error  output  1  misaligned, illegal size, or out-of-range; valid with rsp_valid.
- mem_address  output  32  word index (req_address[31:2], zero-extended).
- mem_write_data  output  32  full word to write.
- mem_write_enable  output  1  write strobe; falling edge commits.
- mem_read_enable  output  1  read strobe; rising edge reads.
- mem_read_data  input  32  memory read word.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - All outputs 0, except req_ready = 1 once reset is released.
  - Request latches cleared.
- States: IDLE, READ, WRITE_SETUP, WRITE_COMMIT, RESPOND. All memory-side outputs are registered.
- IDLE: on accept, latch address/size/unsigned/write/wdata, then:
  - Error if size = 11, or half with addr[0] = 1, or word with addr[1:0] != 0, or addr[31:2] >= MEM_DEPTH. Go to RESPOND with rsp_error = 1; no memory strobe toggles.
  - Load or sub-word store: go to READ.
  - Word store: go to WRITE_SETUP with mem_write_data = req_wdata.
- READ:
  - mem_read_enable = 1 and mem_address is driven for SETTLE_CYCLES cycles (counter).
  - On the last cycle's closing edge, sample mem_read_data.
  - Load: extract lane and extend into rsp_rdata, go to RESPOND.
  - Sub-word store: merge req_wdata lane(s) into the sampled word to form mem_write_data, go to WRITE_SETUP.
  - mem_read_enable drops to 0 on leaving READ.
- WRITE_SETUP: mem_write_enable = 1 for exactly one cycle; mem_address and mem_write_data stable.
- WRITE_COMMIT: mem_write_enable = 0 (this falling edge commits); address and data held unchanged for this full cycle; then go to RESPOND.
- RESPOND: rsp_valid = 1 for one cycle, then IDLE.
- Lane rules:
  - byte lane = addr[1:0], half lane = addr[1].
  - Loads sign-extend bit 7 or bit 15 unless req_unsigned.
  - Word loads pass through unchanged.
- Latency from accept edge to rsp_valid cycle (SETTLE_CYCLES = 1):
  - error: 1
  - load: 2
  - word store: 3
  - sub-word store: 4
  - Each extra settle cycle adds 1 to READ paths.
- Strobe spacing:
  - mem_read_enable is low for ≥ 2 cycles between pulses (RESPOND + IDLE).
  - mem_write_enable is never high while mem_read_enable is high.
- req_ready is low in all non-IDLE states. req_valid held high while busy is ignored until IDLE.
- Reset mid-operation: outputs clear immediately.
  - A reset during WRITE_SETUP produces a falling write strobe. Memory content at that word is undefined; the bench must not check it.
  - Reset during READ is benign.

Decomposition:
- Package memory_access_pkg:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - state encoding;
  - misalignment check function.
- Sub-module load_store_aligner (combinational):
  - load lane extraction and sign/zero extension;
  - store lane merge into the read-back word.

Test Plan:
- Reset low for 3 cycles, then release:
  - During reset: all outputs 0, mem strobes 0.
  - After release: req_ready = 1 on the first cycle.
- Word store 0xDEADBEEF at byte address 0x10:
  - mem_address = 4, mem_write_enable high for 1 cycle then low, rsp_valid 3 cycles after accept.
  - A following word load at 0x10 gives rsp_rdata = 0xDEADBEEF 2 cycles after accept.
- Memory word 3 = 0x11223344; byte store 0xA5 at 0x0F:
  - READ, then write of 0xA5223344, rsp_valid 4 cycles after accept.
  - Signed byte load at 0x0F gives 0xFFFFFFA5; unsigned gives 0x000000A5.
- Memory word 5 = 0x80013344:
  - Signed half load at 0x16 gives 0xFFFF8001.
  - Unsigned half load at 0x14 gives 0x00003344.
- Error requests, each giving rsp_valid 1 cycle after accept, rsp_error = 1, rsp_rdata = 0, and no strobe edges:
  - half at 0x11;
  - word at 0x12;
  - size 11;
  - word at 0x400 (index 256).
- Two loads with req_valid held high:
  - req_ready low while busy; mem_read_enable low ≥ 2 cycles between pulses.
  - Reset asserted during READ of a third load: outputs 0 immediately, IDLE after release.
